uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NB_REQ on-chip requesters using round-robin arbitration. The block sits between client logic and the uart top level. It drives the uart's i_we/i_data and monitors its o_mty. Each grant transfers one byte, paced by transmitter-empty feedback, so no byte is ever written while the transmitter is busy.

Parameters:
WIDTH_DATA, 8, byte width; must match uart WIDTH_DATA.
NB_REQ, 4, number of requesters (2..2^WIDTH_ID).
WIDTH_ID, 2, width of the grant index.
HOLDOFF, 2, cycles after a write during which i_uart_mty is ignored (covers uart mty latency); range 1..15.

Ports:
i_clk  in  1  system clock.
i_nrst  in  1  synchronous active-low reset.
i_req  in  NB_REQ  per-requester level request; held with data stable until ack.
i_data  in  NB_REQ*WIDTH_DATA  requester k byte at bits [k*WIDTH_DATA +: WIDTH_DATA].
o_ack  out  NB_REQ  one-cycle pulse: byte of requester k accepted.
o_uart_we  out  1  write strobe to uart i_we.
o_uart_data  out  WIDTH_DATA  byte to uart i_data; valid while o_uart_we=1.
i_uart_mty  in  1  uart o_mty: 1 = transmitter idle and able to accept a byte.
o_grant_id  out  WIDTH_ID  index of the last granted requester.
o_busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (i_nrst=0 at a rising edge) takes effect at that edge, regardless of state:
  - o_ack=0, o_uart_we=0, o_uart_data=0, o_grant_id=0, o_busy=0.
  - State=IDLE; RR pointer=NB_REQ-1, so requester 0 has top priority first.
  - Any byte in flight is abandoned; no ack is issued for it.
- States: IDLE, WR, HOLD, WAIT.
- IDLE:
  - If |i_req and i_uart_mty=1 at edge T, select g = first set i_req bit searching from pointer+1 upward with wrap.
  - At T+1: o_grant_id=g, pointer=g, o_uart_data=i_data[g], o_uart_we=1, o_ack[g]=1, state=WR.
  - If i_uart_mty=0, stay in IDLE; the request waits and no ack is issued.
- WR: lasts one cycle (the strobe cycle), then go to HOLD with o_uart_we=0 and o_ack=0.
- HOLD: count HOLDOFF cycles with i_uart_mty ignored, then go to WAIT.
- WAIT: go to IDLE on the first cycle i_uart_mty=1.
- Latency: req + mty at edge T gives we/ack at T+1.
- Minimum spacing between strobes = HOLDOFF+3 cycles when mty returns immediately.
- o_uart_data holds its last value outside WR.
- Exactly one o_ack bit is set per grant; o_ack is never asserted outside WR.
- Requests that drop before a grant are simply not served (no error).
- A requester holding i_req across its own ack is treated as a new request and re-arbitrated against the others, giving fairness.
- Single requester: served back-to-back at the minimum spacing.
- Simultaneous requests are resolved purely by RR order; the pointer updates only on a grant.

Optional Feature:
Macro UART_ARB_ID_PREFIX_EN.
- Defined:
  - Each grant sends two bytes: first a header, then the data byte.
  - Header = MSB 1, zeros, low WIDTH_ID bits = g.
  - Sequence: WR(header) -> HOLD -> WAIT -> WR(data) -> HOLD -> WAIT -> IDLE.
  - i_data[g] is latched at grant into an internal register.
  - o_ack[g] pulses in the header WR cycle.
  - o_busy stays 1 across both bytes.
- Undefined: single-byte transfer as above; no header logic or data latch register synthesised.

Test Plan:
- Reset, then i_req=0001, data0=8'h55, mty=1 -> o_uart_we and o_ack[0] one cycle later with o_uart_data=8'h55 and o_grant_id=0; next strobe no earlier than 5 cycles later (HOLDOFF=2).
- i_req=1111 held, distinct bytes 8'h10..8'h13, mty toggling low 10 cycles after each strobe -> grant order 0,1,2,3,0; one ack per strobe; never two strobes without an intervening mty=1.
- mty held 0 with i_req=0010 -> no strobe and no ack; mty raised -> strobe on the next cycle with requester 1's byte.
- Reset asserted during HOLD with i_req=0100 pending -> all outputs 0 at the next edge; after release, requester 0 wins over 2 if both request.
- Requester 2 drops req before grant while requester 3 requests -> only requester 3 served; o_ack[2] never pulses.
- With UART_ARB_ID_PREFIX_EN, i_req=1000, data 8'hC3 -> strobes 8'h83 then 8'hC3; o_ack[3] pulses once, in the first strobe cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NB_REQ requesters.
// Optional UART_ARB_ID_PREFIX_EN prefixes each byte with a header carrying the grant index.
module uart_tx_arbiter #(
   parameter int WIDTH_DATA = 8,
   parameter int NB_REQ     = 4,
   parameter int WIDTH_ID   = 2,
   parameter int HOLDOFF    = 2
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic [NB_REQ-1:0]            i_req,
   input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
   output logic [NB_REQ-1:0]            o_ack,
   output logic                         o_uart_we,
   output logic [WIDTH_DATA-1:0]        o_uart_data,
   input  logic                         i_uart_mty,
   output logic [WIDTH_ID-1:0]          o_grant_id,
   output logic                         o_busy
);
   localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, HOLD = 2'd2, WAIT = 2'd3;
   logic [1:0]            state;
   logic [WIDTH_ID-1:0]   ptr, sel;
   logic                  found;
   logic [3:0]            cnt;
   logic [WIDTH_DATA-1:0] sel_data;
   int                    k;
   always_comb begin
      found = 1'b0;
      sel   = '0;
      k     = 0;
      for (int i = 1; i <= NB_REQ; i++) begin
         k = (int'(ptr) + i) % NB_REQ;
         if (!found && i_req[k]) begin
            found = 1'b1;
            sel   = WIDTH_ID'(k);
         end
      end
   end
   assign sel_data = i_data[int'(sel)*WIDTH_DATA +: WIDTH_DATA];
   assign o_busy   = state != IDLE;
`ifdef UART_ARB_ID_PREFIX_EN
   logic                  second;
   logic [WIDTH_DATA-1:0] latch, hdr;
   always_comb begin
      hdr                 = '0;
      hdr[WIDTH_DATA-1]   = 1'b1;
      hdr[WIDTH_ID-1:0]   = sel;
   end
`endif
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state       <= IDLE;
         ptr         <= WIDTH_ID'(NB_REQ-1);
         o_grant_id  <= '0;
         o_uart_data <= '0;
         o_uart_we   <= 1'b0;
         o_ack       <= '0;
         cnt         <= '0;
`ifdef UART_ARB_ID_PREFIX_EN
         second      <= 1'b0;
         latch       <= '0;
`endif
      end else begin
         o_uart_we <= 1'b0;
         o_ack     <= '0;
         case (state)
            IDLE: if (found && i_uart_mty) begin
               state      <= WR;
               ptr        <= sel;
               o_grant_id <= sel;
               o_uart_we  <= 1'b1;
               o_ack      <= NB_REQ'(1) << sel;
`ifdef UART_ARB_ID_PREFIX_EN
               o_uart_data <= hdr;
               latch       <= sel_data;
               second      <= 1'b0;
`else
               o_uart_data <= sel_data;
`endif
            end
            WR: begin
               state <= HOLD;
               cnt   <= '0;
            end
            // mty lags the write strobe, so it is not trusted until the holdoff expires
            HOLD: if (cnt == 4'(HOLDOFF-1)) state <= WAIT; else cnt <= cnt + 4'd1;
            default: if (i_uart_mty) begin
`ifdef UART_ARB_ID_PREFIX_EN
               if (!second) begin
                  state       <= WR;
                  o_uart_we   <= 1'b1;
                  o_uart_data <= latch;
                  second      <= 1'b1;
               end else state <= IDLE;
`else
               state <= IDLE;
`endif
            end
         endcase
      end
   end
endmodule
